// File: rtl/zx_pkg.sv
// Shared constants and types for the boot-time SPI flash loader.
package zx_pkg;

  localparam logic [7:0]  FLASH_CMD_READ  = 8'h03;
  localparam logic [23:0] DEF_FLASH_ADDR  = 24'h000000;
  localparam int unsigned DEF_LENGTH      = 32768;   // two 16K ROMs

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_CMD,
    ST_DATA,
    ST_DONE
  } ldr_state_t;

  // Byte idx of the 4-byte READ command: opcode then 24-bit address, MSB first.
  function automatic logic [7:0] cmd_byte(input logic [1:0] idx, input logic [23:0] addr);
    case (idx)
      2'd0:    cmd_byte = FLASH_CMD_READ;
      2'd1:    cmd_byte = addr[23:16];
      2'd2:    cmd_byte = addr[15:8];
      default: cmd_byte = addr[7:0];
    endcase
  endfunction

endpackage

// File: rtl/spi_shift8.sv
// 8-bit SPI mode-0 shifter. One half-period per cen; a start on the cen that
// completes a byte chains the next byte with no idle gap.
module spi_shift8 (
  input  logic       clock,
  input  logic       reset,
  input  logic       cen,
  input  logic       start,
  input  logic [7:0] load,
  output logic       done,
  output logic [7:0] rxd,
  output logic       sck,
  output logic       txd,
  input  logic       miso
);

  logic       active;
  logic [3:0] half;
  logic [6:0] txsr;
  logic [6:0] rxsr;

  // done flags the final high half: the next cen samples bit 0 and ends the byte.
  always_comb begin
    done = active && (half == 4'd15);
    rxd  = {rxsr, miso};
  end

  // Half-period sequencing: rise on even->odd, sample/shift on odd->even.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active <= 1'b0;
      half   <= '0;
      txsr   <= '1;
      rxsr   <= '0;
      sck    <= 1'b0;
      txd    <= 1'b1;
    end else if (cen) begin
      if (active) begin
        half <= half + 4'd1;
        if (!half[0]) begin
          sck <= 1'b1;
        end else begin
          sck  <= 1'b0;
          rxsr <= {rxsr[5:0], miso};
          txd  <= txsr[6];
          txsr <= {txsr[5:0], 1'b1};
        end
        if (half == 4'd15) active <= 1'b0;
      end
      if (start) begin
        active <= 1'b1;
        half   <= '0;
        sck    <= 1'b0;
        txd    <= load[7];
        txsr   <= load[6:0];
      end
    end
  end

endmodule

// File: rtl/spi_rom_loader.sv
// Boot loader: READ command to SPI flash, stream LENGTH bytes into SRAM from
// address 0, hold the CPU off via busy until the last write completes.
module spi_rom_loader
  import zx_pkg::*;
#(
  parameter logic [23:0] FLASH_ADDR = DEF_FLASH_ADDR,
  parameter int unsigned LENGTH     = DEF_LENGTH,
  parameter int unsigned AW         = 18
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cen,
  output logic          busy,
  output logic [AW-1:0] memA,
  output logic [7:0]    memD,
  output logic          memWr,
  output logic          spiCs,
  output logic          spiCk,
  output logic          spiDi,
  input  logic          spiDo
);

  localparam logic [AW:0] LEN_C = (AW+1)'(LENGTH);

  ldr_state_t  state, state_d;
  logic [2:0]  wcnt;
  logic [1:0]  cidx;
  logic [AW:0] bcnt;
  logic        sh_start;
  logic [7:0]  sh_load;
  logic        sh_done;
  logic [7:0]  sh_rxd;

  spi_shift8 u_shift (
    .clock (clock),
    .reset (reset),
    .cen   (cen),
    .start (sh_start),
    .load  (sh_load),
    .done  (sh_done),
    .rxd   (sh_rxd),
    .sck   (spiCk),
    .txd   (spiDi),
    .miso  (spiDo)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)   state <= ST_WAIT;
    else if (cen) state <= state_d;
  end

  // Next state and shifter byte sequencing; data bytes transmit all-ones.
  always_comb begin
    state_d  = state;
    sh_start = 1'b0;
    sh_load  = 8'hFF;
    case (state)
      ST_WAIT: begin
        if (wcnt == 3'd7) begin
          sh_start = 1'b1;
          sh_load  = FLASH_CMD_READ;
          state_d  = ST_CMD;
        end
      end
      ST_CMD: begin
        if (sh_done) begin
          sh_start = 1'b1;
          if (cidx == 2'd3) state_d = ST_DATA;
          else              sh_load = cmd_byte(cidx + 2'd1, FLASH_ADDR);
        end
      end
      ST_DATA: begin
        if (sh_done && (bcnt != LEN_C - (AW+1)'(1))) sh_start = 1'b1;
        // Leave only once the final write pulse is being cleared.
        if (memWr && (bcnt == LEN_C)) state_d = ST_DONE;
      end
      default: ;
    endcase
  end

  // Counters, SRAM write port and chip select / busy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wcnt  <= '0;
      cidx  <= '0;
      bcnt  <= '0;
      memWr <= 1'b0;
      memA  <= '0;
      memD  <= '0;
      spiCs <= 1'b1;
      busy  <= 1'b1;
    end else if (cen) begin
      if (state == ST_WAIT) begin
        wcnt <= wcnt + 3'd1;
        if (sh_start) spiCs <= 1'b0;
      end
      if (state == ST_CMD && sh_done) cidx <= cidx + 2'd1;
      if (state == ST_DATA && sh_done) begin
        memWr <= 1'b1;
        memD  <= sh_rxd;
        bcnt  <= bcnt + (AW+1)'(1);
      end
      if (memWr) begin
        memWr <= 1'b0;
        memA  <= memA + AW'(1);
      end
      if (state == ST_DATA && state_d == ST_DONE) begin
        spiCs <= 1'b1;
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_rom_loader.sv
// Bench for spi_rom_loader: flash models, write scoreboard, timing checks.
module tb_spi_rom_loader;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic cen   = 1'b0;

  logic        busy_a, memWr_a, cs_a, ck_a, di_a;
  logic        do_a = 1'b0;
  logic [17:0] memA_a;
  logic [7:0]  memD_a;
  logic        busy_b, memWr_b, cs_b, ck_b, di_b;
  logic [17:0] memA_b;
  logic [7:0]  memD_b;

  spi_rom_loader #(.FLASH_ADDR(24'h123456), .LENGTH(4), .AW(18)) dut_a (
    .clock(clock), .reset(reset), .cen(cen), .busy(busy_a), .memA(memA_a),
    .memD(memD_a), .memWr(memWr_a), .spiCs(cs_a), .spiCk(ck_a), .spiDi(di_a),
    .spiDo(do_a));

  spi_rom_loader #(.FLASH_ADDR(24'h000000), .LENGTH(1), .AW(18)) dut_b (
    .clock(clock), .reset(reset), .cen(cen), .busy(busy_b), .memA(memA_b),
    .memD(memD_b), .memWr(memWr_b), .spiCs(cs_b), .spiCk(ck_b), .spiDi(di_b),
    .spiDo(1'b1));

  always #5 clock = ~clock;

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // cen generator: one cen every 'period' clocks.
  int unsigned period = 1;
  int unsigned cdiv   = 0;
  always @(negedge clock) begin
    cdiv = (cdiv + 1 >= period) ? 0 : cdiv + 1;
    cen  = (cdiv == 0);
  end

  // Flash models: capture MOSI on rising SCK, drive MISO just after it.
  logic [7:0]  img_a [4];
  logic [31:0] cmd_a, cmd_b;
  int unsigned edges_a = 0, edges_b = 0;

  always @(negedge cs_a) edges_a = 0;
  always @(negedge cs_b) edges_b = 0;

  always @(posedge ck_a) begin
    int unsigned k;
    logic nxt;
    if (!cs_a) begin
      if (edges_a < 32) begin
        cmd_a = {cmd_a[30:0], di_a};
        edges_a++;
      end else begin
        k = edges_a - 32;
        nxt = (k / 8 < 4) ? img_a[k/8][7 - (k % 8)] : 1'b1;
        edges_a++;
        #1 do_a = nxt;
      end
    end
  end

  always @(posedge ck_b) begin
    if (!cs_b) begin
      if (edges_b < 32) cmd_b = {cmd_b[30:0], di_b};
      edges_b++;
    end
  end

  // Scoreboards of expected {addr,data} writes.
  logic [25:0] exp_a[$];
  logic [25:0] exp_b[$];

  int unsigned exp_width = 1;
  logic        chk_frozen = 1'b0;
  int unsigned cen_cnt = 0;
  int unsigned wr_cnt_a = 0, wr_cnt_b = 0, rises_a = 0;
  int unsigned busy_fall_a = 0, busy_fall_b = 0;
  int unsigned plen_a = 0, plen_b = 0;
  logic        wrp_a = 0, wrp_b = 0, ckp_a = 0, busyp_a = 1, busyp_b = 1;
  logic [25:0] held_a, held_b, exp_w;
  logic [30:0] out_a, last_out_a = '0;
  logic        cen_at;

  // Output monitor, sampled 1 time unit after each rising clock edge.
  always @(posedge clock) begin
    cen_at = cen;
    #1;
    out_a = {busy_a, memA_a, memD_a, memWr_a, cs_a, ck_a, di_a};
    if (!reset) begin
      cen_cnt = 0; wrp_a = 0; wrp_b = 0; ckp_a = 0; busyp_a = 1; busyp_b = 1;
    end else begin
      if (cen_at) cen_cnt++;
      if (chk_frozen && !cen_at) check("frozen", out_a, last_out_a);
      if (cs_a) begin
        check("ck_idle", ck_a, 1'b0);
        check("di_idle", di_a, 1'b1);
      end
      if (ck_a && !ckp_a) begin
        rises_a++;
        check("cs_low", cs_a, 1'b0);
      end
      ckp_a = ck_a;
      if (busyp_a && !busy_a) busy_fall_a = cen_cnt;
      if (busyp_b && !busy_b) busy_fall_b = cen_cnt;
      busyp_a = busy_a; busyp_b = busy_b;
      // Instance A writes
      if (memWr_a && !wrp_a) begin
        held_a = {memA_a, memD_a};
        plen_a = 1;
        wr_cnt_a++;
        if (exp_a.size() == 0) check("wr_extra_a", 1'b1, 1'b0);
        else begin exp_w = exp_a.pop_front(); check("wr_a", held_a, exp_w); end
      end else if (memWr_a) begin
        plen_a++;
        check("wr_stable_a", {memA_a, memD_a}, held_a);
      end else if (wrp_a) check("wr_width_a", plen_a, exp_width);
      wrp_a = memWr_a;
      // Instance B writes
      if (memWr_b && !wrp_b) begin
        held_b = {memA_b, memD_b};
        plen_b = 1;
        wr_cnt_b++;
        if (exp_b.size() == 0) check("wr_extra_b", 1'b1, 1'b0);
        else begin exp_w = exp_b.pop_front(); check("wr_b", held_b, exp_w); end
      end else if (memWr_b) plen_b++;
      else if (wrp_b) check("wr_width_b", plen_b, exp_width);
      wrp_b = memWr_b;
    end
    last_out_a = out_a;
  end

  task automatic start_run;
    exp_a.delete();
    for (int unsigned i = 0; i < 4; i++) exp_a.push_back({18'(i), img_a[i]});
    exp_b.delete();
    exp_b.push_back({18'd0, 8'hFF});
    wr_cnt_a = 0; wr_cnt_b = 0; rises_a = 0;
    busy_fall_a = 0; busy_fall_b = 0;
    cmd_a = '0; cmd_b = '0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic wait_done(input int unsigned max_clk);
    int unsigned n;
    n = 0;
    while (busy_a && n < max_clk) begin
      @(posedge clock);
      n++;
    end
    check("busy_timeout", busy_a, 1'b0);
    repeat (2) @(posedge clock);
    #2;
  endtask

  task automatic run_checks;
    check("cmd_a", cmd_a, 32'h03123456);
    check("lat_a", busy_fall_a, 137);
    check("sb_empty_a", exp_a.size(), 0);
    check("wr_cnt_a", wr_cnt_a, 4);
    check("rises_a", rises_a, 64);
    check("memA_done", memA_a, 18'd4);
    check("cs_done", cs_a, 1'b1);
  endtask

  initial begin
    int unsigned n;
    logic found;
    img_a[0] = 8'hA5; img_a[1] = 8'h3C; img_a[2] = 8'h00; img_a[3] = 8'hFF;
    repeat (3) @(posedge clock);
    #2;
    check("rst_busy", busy_a, 1'b1);
    check("rst_cs", cs_a, 1'b1);
    check("rst_ck", ck_a, 1'b0);
    check("rst_di", di_a, 1'b1);
    check("rst_wr", memWr_a, 1'b0);
    check("rst_memA", memA_a, 18'd0);
    check("rst_memD", memD_a, 8'd0);

    // Run 1: cen every clock
    start_run();
    wait_done(3000);
    run_checks();
    check("lat_b", busy_fall_b, 89);
    check("cmd_b", cmd_b, 32'h03000000);
    check("sb_empty_b", exp_b.size(), 0);
    check("wr_cnt_b", wr_cnt_b, 1);

    // Run 2: cen 1 in 3, byte 2 = B2 checks sampling at end of high half
    @(negedge clock);
    reset = 1'b0;
    img_a[2] = 8'hB2;
    period = 3;
    exp_width = 3;
    repeat (3) @(negedge clock);
    start_run();
    chk_frozen = 1'b1;
    wait_done(9000);
    repeat (4) @(posedge clock);
    #2;
    chk_frozen = 1'b0;
    run_checks();

    // Run 3: abort during DATA while byte 1 is being written
    @(negedge clock);
    reset = 1'b0;
    period = 1;
    exp_width = 1;
    repeat (3) @(negedge clock);
    start_run();
    found = 1'b0;
    n = 0;
    while (!found && n < 2000) begin
      @(posedge clock);
      #3;
      n++;
      if (wr_cnt_a == 2 && memWr_a) found = 1'b1;
    end
    check("byte1_seen", found, 1'b1);
    reset = 1'b0;
    #1;
    check("abort_cs", cs_a, 1'b1);
    check("abort_busy", busy_a, 1'b1);
    check("abort_wr", memWr_a, 1'b0);
    check("abort_ck", ck_a, 1'b0);
    repeat (3) @(negedge clock);
    start_run();
    wait_done(3000);
    run_checks();

    // LENGTH=1 instance must stay idle in DONE
    repeat (1000) @(posedge clock);
    #2;
    check("idle_wr_cnt_b", wr_cnt_b, 1);
    check("idle_busy_b", busy_b, 1'b0);
    check("idle_cs_b", cs_b, 1'b1);
    check("idle_ck_b", ck_b, 1'b0);
    check("idle_di_b", di_b, 1'b1);
    check("idle_memD_b", memD_b, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
